// File: rtl/alu_pkg.sv
// Shared encodings for the ALU writeback path: condition codes, op types, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_C      = 2'b01;
   localparam logic [1:0] COND_Z      = 2'b10;
   localparam logic [1:0] COND_NEVER  = 2'b11;

   localparam logic OP_ADD  = 1'b0;
   localparam logic OP_NAND = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } wb_state_t;

   // True when an instruction with condition 'cond' executes given the current flags.
   function automatic logic cond_pass(input logic [1:0] cond, input logic c, input logic z);
      logic pass;
      case (cond)
         COND_ALWAYS: pass = 1'b1;
         COND_C:      pass = c;
         COND_Z:      pass = z;
         COND_NEVER:  pass = 1'b0;
         default:     pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/alu_writeback_ctrl_flag_reg.sv
// Architectural carry/zero flag register; Z loads on upd_en, C only when upd_c_en also set.
// Latency: new values visible the cycle after the update edge.
// Backpressure: none; updates are single-cycle strobes from the owning stage.
module flag_reg (
   input  logic clk,
   input  logic rst_n,
   input  logic upd_en,
   input  logic upd_c_en,
   input  logic new_c,
   input  logic new_z,
   output logic flag_c,
   output logic flag_z
);

   logic c_q, c_d;
   logic z_q, z_d;

   // Next-flag selection: Z follows every update, C only when the op produces a carry.
   always_comb begin
      c_d = c_q;
      z_d = z_q;
      if (upd_en) begin
         z_d = new_z;
         if (upd_c_en) begin
            c_d = new_c;
         end
      end
   end

   // Flag state, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= 1'b0;
         z_q <= 1'b0;
      end else begin
         c_q <= c_d;
         z_q <= z_d;
      end
   end

   assign flag_c = c_q;
   assign flag_z = z_q;

endmodule

// File: rtl/alu_writeback_ctrl.sv
// ALU writeback stage: evaluates condition vs C/Z, commits result to the RF, then updates flags.
// Latency: accept at T, commit at T+2 (ready high), wb_done during T+2..T+3; skip retires at T+1.
// Backpressure: ex_ready only in IDLE; WRITE holds rf_wr_en/addr/data until rf_wr_ready.
module alu_writeback_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_carry,
   input  logic              ex_op,
   input  logic [1:0]        ex_cond,
   input  logic [REG_AW-1:0] ex_rd,
   output logic              rf_wr_en,
   output logic [REG_AW-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   input  logic              rf_wr_ready,
   output logic              flag_c,
   output logic              flag_z,
   output logic              wb_done,
   output logic              wb_skipped,
   output logic [CNT_W-1:0]  wr_count
);

   wb_state_t         state_q, state_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              carry_q, carry_d;
   logic              op_q, op_d;
   logic [1:0]        cond_q, cond_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              skip_q, skip_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              live_q;

   logic upd_en;
   logic upd_c_en;
   logic exec;

   // Condition uses the flags as they stand before this instruction commits.
   assign exec = cond_pass(cond_q, flag_c, flag_z);

   // FSM next state, holding-register capture, commit and flag-update strobes.
   always_comb begin
      state_d  = state_q;
      res_d    = res_q;
      carry_d  = carry_q;
      op_d     = op_q;
      cond_d   = cond_q;
      rd_d     = rd_q;
      skip_d   = skip_q;
      cnt_d    = cnt_q;
      upd_en   = 1'b0;
      upd_c_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_valid && live_q) begin
               res_d   = ex_result;
               carry_d = ex_carry;
               op_d    = ex_op;
               cond_d  = ex_cond;
               rd_d    = ex_rd;
               state_d = EVAL;
            end
         end
         EVAL: begin
            skip_d  = ~exec;
            state_d = exec ? WRITE : DONE;
         end
         WRITE: begin
            if (rf_wr_ready) begin
               upd_en   = 1'b1;
               upd_c_en = (op_q == OP_ADD);
               cnt_d    = cnt_q + CNT_W'(1);
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, holding registers and committed-write counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         res_q   <= '0;
         carry_q <= 1'b0;
         op_q    <= OP_ADD;
         cond_q  <= COND_ALWAYS;
         rd_q    <= '0;
         skip_q  <= 1'b0;
         cnt_q   <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         op_q    <= op_d;
         cond_q  <= cond_d;
         rd_q    <= rd_d;
         skip_q  <= skip_d;
         cnt_q   <= cnt_d;
         live_q  <= 1'b1;
      end
   end

   flag_reg u_flag_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd_en   (upd_en),
      .upd_c_en (upd_c_en),
      .new_c    (carry_q),
      .new_z    (res_q == '0),
      .flag_c   (flag_c),
      .flag_z   (flag_z)
   );

   // live_q keeps ex_ready low until the first clock after reset release.
   assign ex_ready   = (state_q == IDLE) && live_q;
   assign rf_wr_en   = (state_q == WRITE);
   assign rf_wr_addr = rd_q;
   assign rf_wr_data = res_q;
   assign wb_done    = (state_q == DONE);
   assign wb_skipped = (state_q == DONE) && skip_q;
   assign wr_count   = cnt_q;

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
module tb_alu_writeback_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [15:0] ex_result = '0;
   logic        ex_carry = 1'b0;
   logic        ex_op = 1'b0;
   logic [1:0]  ex_cond = 2'b00;
   logic [2:0]  ex_rd = '0;
   logic        rf_wr_en;
   logic [2:0]  rf_wr_addr;
   logic [15:0] rf_wr_data;
   logic        rf_wr_ready = 1'b1;
   logic        flag_c, flag_z, wb_done, wb_skipped;
   logic [15:0] wr_count;

   // Small-counter instance for the wrap check.
   logic        w_valid = 1'b0;
   logic        w_ready, w_en, w_c, w_z, w_done, w_skip;
   logic [2:0]  w_addr;
   logic [15:0] w_data;
   logic [1:0]  w_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_writeback_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_result(ex_result), .ex_carry(ex_carry), .ex_op(ex_op), .ex_cond(ex_cond),
      .ex_rd(ex_rd), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .rf_wr_ready(rf_wr_ready), .flag_c(flag_c), .flag_z(flag_z), .wb_done(wb_done),
      .wb_skipped(wb_skipped), .wr_count(wr_count)
   );

   alu_writeback_ctrl #(.DATA_W(16), .REG_AW(3), .CNT_W(2)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .ex_valid(w_valid), .ex_ready(w_ready),
      .ex_result(16'h0001), .ex_carry(1'b0), .ex_op(1'b0), .ex_cond(2'b00),
      .ex_rd(3'd1), .rf_wr_en(w_en), .rf_wr_addr(w_addr), .rf_wr_data(w_data),
      .rf_wr_ready(1'b1), .flag_c(w_c), .flag_z(w_z), .wb_done(w_done),
      .wb_skipped(w_skip), .wr_count(w_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction with rf_wr_ready high and check the whole retire sequence.
   task automatic run_instr(input string tag, input logic op, input logic [1:0] cond,
                            input logic [15:0] res, input logic carry, input logic [2:0] rd,
                            input logic exp_exec, input logic exp_c, input logic exp_z,
                            input logic [15:0] exp_cnt);
      ex_op = op; ex_cond = cond; ex_result = res; ex_carry = carry; ex_rd = rd;
      ex_valid = 1'b1;
      step();
      ex_valid = 1'b0;
      ex_result = ~res;
      chk({tag, "_eval_rdy"}, ex_ready, 0);
      chk({tag, "_eval_done"}, wb_done, 0);
      if (exp_exec) begin
         step();
         chk({tag, "_wr_en"}, rf_wr_en, 1);
         chk({tag, "_wr_addr"}, rf_wr_addr, rd);
         chk({tag, "_wr_data"}, rf_wr_data, res);
      end
      step();
      chk({tag, "_done"}, wb_done, 1);
      chk({tag, "_skip"}, wb_skipped, !exp_exec);
      chk({tag, "_no_wr"}, rf_wr_en, 0);
      chk({tag, "_c"}, flag_c, exp_c);
      chk({tag, "_z"}, flag_z, exp_z);
      chk({tag, "_cnt"}, wr_count, exp_cnt);
      step();
      chk({tag, "_done_off"}, wb_done, 0);
      chk({tag, "_rdy_back"}, ex_ready, 1);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_c", flag_c, 0);
      chk("rst_z", flag_z, 0);
      chk("rst_wr_en", rf_wr_en, 0);
      chk("rst_done", wb_done, 0);
      chk("rst_skip", wb_skipped, 0);
      chk("rst_cnt", wr_count, 0);
      chk("rst_rdy", ex_ready, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_rdy", ex_ready, 1);

      // 1: ADD always, zero result with carry
      run_instr("t1", OP_ADD, COND_ALWAYS, 16'h0000, 1'b1, 3'd3, 1, 1, 1, 16'd1);
      // 2: ADC taken with C=1, then ADC skipped with C=0
      run_instr("t2a", OP_ADD, COND_C, 16'h1234, 1'b0, 3'd4, 1, 0, 0, 16'd2);
      run_instr("t2b", OP_ADD, COND_C, 16'h0001, 1'b1, 3'd4, 0, 0, 0, 16'd2);
      // 3: set C, then NAND leaves C alone even with carry 0
      run_instr("t3a", OP_ADD, COND_ALWAYS, 16'h8000, 1'b1, 3'd1, 1, 1, 0, 16'd3);
      run_instr("t3b", OP_NAND, COND_ALWAYS, 16'hFFFF, 1'b1, 3'd2, 1, 1, 0, 16'd4);
      run_instr("t3c", OP_NAND, COND_ALWAYS, 16'h0000, 1'b0, 3'd2, 1, 1, 1, 16'd5);
      // ADZ taken with Z=1, then ADZ skipped with Z=0
      run_instr("t3d", OP_ADD, COND_Z, 16'h0005, 1'b0, 3'd6, 1, 0, 0, 16'd6);
      run_instr("t3e", OP_ADD, COND_Z, 16'h0000, 1'b1, 3'd6, 0, 0, 0, 16'd6);
      // 4: cond never
      run_instr("t4a", OP_ADD, COND_NEVER, 16'h0000, 1'b1, 3'd7, 0, 0, 0, 16'd6);
      run_instr("t4b", OP_NAND, COND_NEVER, 16'h0000, 1'b1, 3'd7, 0, 0, 0, 16'd6);

      // 5: RF stalls 5 cycles in WRITE
      rf_wr_ready = 1'b0;
      ex_op = OP_ADD; ex_cond = COND_ALWAYS; ex_result = 16'hABCD; ex_carry = 1'b1; ex_rd = 3'd5;
      ex_valid = 1'b1;
      step();
      ex_valid = 1'b0;
      ex_result = 16'h5555;
      ex_rd = 3'd0;
      step();
      for (int i = 0; i < 6; i++) begin
         chk("t5_en", rf_wr_en, 1);
         chk("t5_addr", rf_wr_addr, 3'd5);
         chk("t5_data", rf_wr_data, 16'hABCD);
         chk("t5_rdy", ex_ready, 0);
         chk("t5_c_hold", flag_c, 0);
         chk("t5_done_hold", wb_done, 0);
         if (i == 5) rf_wr_ready = 1'b1;
         step();
      end
      chk("t5_done", wb_done, 1);
      chk("t5_c", flag_c, 1);
      chk("t5_z", flag_z, 0);
      chk("t5_cnt", wr_count, 16'd7);
      step();

      // 6: reset pulse during a stalled WRITE
      rf_wr_ready = 1'b0;
      ex_op = OP_ADD; ex_cond = COND_ALWAYS; ex_result = 16'h0000; ex_carry = 1'b0; ex_rd = 3'd2;
      ex_valid = 1'b1;
      step();
      ex_valid = 1'b0;
      step();
      chk("t6_in_write", rf_wr_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_en_drop", rf_wr_en, 0);
      chk("t6_c", flag_c, 0);
      chk("t6_z", flag_z, 0);
      chk("t6_cnt", wr_count, 0);
      chk("t6_done", wb_done, 0);
      rf_wr_ready = 1'b1;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_no_done", wb_done, 0);
         chk("t6_no_wr", rf_wr_en, 0);
      end

      // Counter wrap on the 2-bit instance
      for (int k = 1; k <= 4; k++) begin
         w_valid = 1'b1;
         step();
         w_valid = 1'b0;
         repeat (3) step();
         chk("wrap_cnt", w_count, k % 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
